// File: rtl/toy_bus_arb_rr_req_2to1_if.sv
// One ToyBusReq request channel: valid/ready handshake plus the 77-bit request payload.
// The master drives valid and payload, and the slave answers with ready.
interface toy_bus_arb_rr_req_2to1_if;
   logic        vld;
   logic        rdy;
   logic [31:0] addr;
   logic [3:0]  strb;
   logic [31:0] data;
   logic        opcode;
   logic [3:0]  src_id;
   logic [3:0]  tgt_id;

   modport master (
      output vld, addr, strb, data, opcode, src_id, tgt_id,
      input  rdy
   );

   modport slave (
      input  vld, addr, strb, data, opcode, src_id, tgt_id,
      output rdy
   );
endinterface

// File: rtl/toy_bus_arb_rr_req_2to1.sv
// Two-input round-robin arbiter merging two ToyBusReq streams into one registered forward slice.
// The priority pointer moves only when a transfer is accepted, so a stalled output keeps the current turn.
module toy_bus_arb_rr_req_2to1 #(
   parameter bit RESET_PRIO = 1'b0
) (
   input  logic                             clk,
   input  logic                             rst,
   toy_bus_arb_rr_req_2to1_if.slave         in0,
   toy_bus_arb_rr_req_2to1_if.slave         in1,
   toy_bus_arb_rr_req_2to1_if.master        out0
);

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
      logic        opcode;
      logic [3:0]  src_id;
      logic [3:0]  tgt_id;
   } payload_t;

   logic     out_vld_q, out_vld_d;
   payload_t payload_q, payload_d;
   logic     prio_q, prio_d;

   payload_t pl0, pl1;
   logic     slot_free;
   logic     gnt0, gnt1;
   logic     rdy0, rdy1;
   logic     acc0, acc1;

   assign pl0 = '{addr: in0.addr, strb: in0.strb, data: in0.data,
                  opcode: in0.opcode, src_id: in0.src_id, tgt_id: in0.tgt_id};
   assign pl1 = '{addr: in1.addr, strb: in1.strb, data: in1.data,
                  opcode: in1.opcode, src_id: in1.src_id, tgt_id: in1.tgt_id};

   always_comb begin
      // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
      out_vld_d = out_vld_q;
      payload_d = payload_q;
      prio_d    = prio_q;

      // The slice can take a beat when it is empty or is being drained this cycle.
      slot_free = !out_vld_q || out0.rdy;
      gnt0      = in0.vld && (!in1.vld || !prio_q);
      gnt1      = in1.vld && (!in0.vld ||  prio_q);
      rdy0      = gnt0 && slot_free && !rst;
      rdy1      = gnt1 && slot_free && !rst;
      acc0      = in0.vld && rdy0;
      acc1      = in1.vld && rdy1;

      if (acc0) begin
         out_vld_d = 1'b1;
         payload_d = pl0;
         prio_d    = 1'b1;
      end else if (acc1) begin
         out_vld_d = 1'b1;
         payload_d = pl1;
         prio_d    = 1'b0;
      end else if (out0.rdy) begin
         out_vld_d = 1'b0;
      end
   end

   assign in0.rdy = rdy0;
   assign in1.rdy = rdy1;

   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      // The payload register is reset as well, so out0 reads all-zero after reset, not stale data.
      if (rst) begin
         out_vld_q <= 1'b0;
         payload_q <= '0;
         prio_q    <= RESET_PRIO;
      end else begin
         out_vld_q <= out_vld_d;
         payload_q <= payload_d;
         prio_q    <= prio_d;
      end
   end

   assign out0.vld    = out_vld_q;
   assign out0.addr   = payload_q.addr;
   assign out0.strb   = payload_q.strb;
   assign out0.data   = payload_q.data;
   assign out0.opcode = payload_q.opcode;
   assign out0.src_id = payload_q.src_id;
   assign out0.tgt_id = payload_q.tgt_id;

endmodule

// File: tb/tb_toy_bus_arb_rr_req_2to1.sv
// Self-checking bench for toy_bus_arb_rr_req_2to1: directed scenarios and then random traffic.
// The reference model tracks the output slot, the turn and a FIFO scoreboard of accepted beats.
module tb_toy_bus_arb_rr_req_2to1;
   localparam bit RESET_PRIO = 1'b0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   toy_bus_arb_rr_req_2to1_if in0_if ();
   toy_bus_arb_rr_req_2to1_if in1_if ();
   toy_bus_arb_rr_req_2to1_if out0_if ();

   toy_bus_arb_rr_req_2to1 #(.RESET_PRIO(RESET_PRIO)) dut (
      .clk  (clk),
      .rst  (rst),
      .in0  (in0_if),
      .in1  (in1_if),
      .out0 (out0_if)
   );

   int checks = 0;
   int errors = 0;

   // Upstream stimulus state: pending payload and valid for each input.
   logic [76:0] pend [2];
   bit          vld_in [2];
   bit          out_rdy;

   // Reference model.
   bit          m_vld;
   logic [76:0] m_pl;
   bit          m_prio;
   logic [76:0] sb [$];
   logic [31:0] addr_log [$];
   int          last_w;
   int          pops;

   task automatic check(input string tag, input logic [76:0] got, input logic [76:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [76:0] mk(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] tgt);
      return {addr, 4'hF, data, 1'b1, 4'h1, tgt};
   endfunction

   function automatic logic [76:0] rand_pl();
      logic [31:0] a, d;
      logic [3:0]  s, si, ti;
      logic        op;
      a  = $urandom;
      d  = $urandom;
      s  = 4'($urandom);
      si = 4'($urandom);
      ti = 4'($urandom);
      op = 1'($urandom);
      return {a, s, d, op, si, ti};
   endfunction

   function automatic logic [76:0] out_pl();
      return {out0_if.addr, out0_if.strb, out0_if.data, out0_if.opcode,
              out0_if.src_id, out0_if.tgt_id};
   endfunction

   task automatic apply();
      in0_if.vld = vld_in[0];
      in1_if.vld = vld_in[1];
      {in0_if.addr, in0_if.strb, in0_if.data, in0_if.opcode, in0_if.src_id, in0_if.tgt_id} = pend[0];
      {in1_if.addr, in1_if.strb, in1_if.data, in1_if.opcode, in1_if.src_id, in1_if.tgt_id} = pend[1];
      out0_if.rdy = out_rdy;
   endtask

   // One clock: check ready before the edge, advance the model at the edge, check outputs after it.
   task automatic cycle();
      int w;
      apply();
      #1;
      w = -1;
      if (!rst && (!m_vld || out_rdy)) begin
         if (vld_in[0] && vld_in[1]) w = m_prio ? 1 : 0;
         else if (vld_in[0])         w = 0;
         else if (vld_in[1])         w = 1;
      end
      check("in0_rdy", 77'(in0_if.rdy), 77'(w == 0));
      check("in1_rdy", 77'(in1_if.rdy), 77'(w == 1));
      if (!rst && out0_if.vld && out_rdy) begin
         pops++;
         addr_log.push_back(out0_if.addr);
         if (sb.size() == 0) check("unexpected_pop", 77'(1), 77'(0));
         else                check("pop_order", out_pl(), sb.pop_front());
      end
      last_w = w;
      @(posedge clk);
      if (rst) begin
         m_vld  = 1'b0;
         m_pl   = '0;
         m_prio = RESET_PRIO;
         sb.delete();
      end else if (w >= 0) begin
         m_vld  = 1'b1;
         m_pl   = pend[w];
         m_prio = (w == 0);
         sb.push_back(pend[w]);
      end else if (out_rdy) begin
         m_vld = 1'b0;
      end
      #1;
      check("out_vld", 77'(out0_if.vld), 77'(m_vld));
      check("out_pl", out_pl(), m_pl);
      check("prio", 77'(dut.prio_q), 77'(m_prio));
      @(negedge clk);
   endtask

   initial begin
      int k0, k1, pops_before;
      logic [31:0] exp_addr;
      rst = 1'b1;
      out_rdy = 1'b1;
      vld_in[0] = 1'b1;
      vld_in[1] = 1'b1;
      pend[0] = mk(32'hA0, 32'h0, 4'h2);
      pend[1] = mk(32'hB0, 32'h0, 4'h3);
      m_vld = 1'b0; m_pl = '0; m_prio = RESET_PRIO; pops = 0;
      @(negedge clk);

      // Reset held for 3 cycles with both inputs requesting.
      repeat (3) cycle();
      check("rst_out_vld", 77'(out0_if.vld), 77'(0));
      check("rst_out_pl", out_pl(), 77'(0));
      rst = 1'b0;
      cycle();
      check("rst_first_tgt", 77'(out0_if.tgt_id), 77'(4'h2));
      check("rst_first_addr", 77'(out0_if.addr), 77'(32'hA0));

      // Strict alternation from a fresh reset.
      rst = 1'b1; vld_in[0] = 1'b0; vld_in[1] = 1'b0;
      cycle();
      rst = 1'b0;
      addr_log.delete();
      k0 = 0; k1 = 0;
      pend[0] = mk(32'h1000, 32'h11, 4'h0);
      pend[1] = mk(32'h2000, 32'h22, 4'h1);
      vld_in[0] = 1'b1; vld_in[1] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         cycle();
         if (last_w == 0) begin k0++; pend[0] = mk(32'h1000 + k0, 32'h11, 4'h0); end
         if (last_w == 1) begin k1++; pend[1] = mk(32'h2000 + k1, 32'h22, 4'h1); end
      end
      vld_in[0] = 1'b0; vld_in[1] = 1'b0;
      cycle();
      check("alt_count", 77'(addr_log.size()), 77'(6));
      for (int i = 0; i < 6 && i < addr_log.size(); i++) begin
         exp_addr = ((i % 2) == 0) ? 32'h1000 + i / 2 : 32'h2000 + i / 2;
         check("alt_addr", 77'(addr_log[i]), 77'(exp_addr));
      end

      // Single requester on in1, four back-to-back beats.
      vld_in[1] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         pend[1] = mk(32'h600 + c, 32'h66, 4'h5);
         cycle();
      end
      vld_in[1] = 1'b0;
      check("single_prio", 77'(dut.prio_q), 77'(0));
      cycle();

      // Stall: beat DEADBEEF held for 5 cycles with both inputs requesting.
      pend[0] = mk(32'h3000, 32'hDEADBEEF, 4'h7);
      vld_in[0] = 1'b1;
      cycle();
      pend[0] = mk(32'h3001, 32'h31, 4'h7);
      pend[1] = mk(32'h4000, 32'h41, 4'h8);
      vld_in[1] = 1'b1;
      out_rdy = 1'b0;
      repeat (5) begin
         cycle();
         check("stall_data", 77'(out0_if.data), 77'(32'hDEADBEEF));
         check("stall_prio", 77'(dut.prio_q), 77'(1));
      end
      out_rdy = 1'b1;
      cycle();
      check("stall_release_addr", 77'(out0_if.addr), 77'(32'h4000));
      vld_in[1] = 1'b0;

      // Mid-flight reset drops the beat in the slice.
      out_rdy = 1'b0;
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      vld_in[0] = 1'b0;
      out_rdy = 1'b1;
      pops_before = pops;
      repeat (2) cycle();
      check("drop_no_pop", 77'(pops), 77'(pops_before));
      check("drop_prio", 77'(dut.prio_q), 77'(RESET_PRIO));

      // Same-cycle push and pop.
      pend[0] = mk(32'h5000, 32'h50, 4'h9);
      vld_in[0] = 1'b1;
      cycle();
      pend[0] = mk(32'h5001, 32'h51, 4'h9);
      cycle();
      check("pushpop_vld", 77'(out0_if.vld), 77'(1));
      check("pushpop_addr", 77'(out0_if.addr), 77'(32'h5001));
      vld_in[0] = 1'b0;

      // Random traffic respecting the upstream hold-until-ready rule.
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         out_rdy = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 2; i++) begin
            if (!vld_in[i]) begin
               vld_in[i] = 1'($urandom);
               if (vld_in[i]) pend[i] = rand_pl();
            end
         end
         cycle();
         if (last_w >= 0) vld_in[last_w] = 1'b0;
      end
      rst = 1'b0;
      vld_in[0] = 1'b0; vld_in[1] = 1'b0;
      out_rdy = 1'b1;
      repeat (3) cycle();
      check("drain_empty", 77'(sb.size()), 77'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
